midi_voice_allocator: RTL

Parses a MIDI byte stream and assigns note-on/note-off events to a bank of `NUM_VOICES` voices, driving each voice's gate, note number and amplitude. Sits directly upstream of the voice bank: its per-voice outputs connect to each voice's `enable`, `midi_data` and `amplitude` inputs. Bytes arrive from the MIDI UART receiver.

---
 rtl/midi_defs.sv | 17 +
 rtl/midi_msg_parser.sv | 84 ++++++++
 rtl/midi_voice_allocator.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/midi_defs.sv
// Shared definitions for the MIDI voice allocator: status constants,
// real-time byte threshold, parser state encoding and default voice count.
package midi_defs;

    localparam logic [7:0] MIDI_NOTE_OFF      = 8'h80;
    localparam logic [7:0] MIDI_NOTE_ON       = 8'h90;
    localparam logic [7:0] MIDI_RT_THRESHOLD  = 8'hF8;
    localparam int         DEFAULT_NUM_VOICES = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_D1 = 2'd1,
        ST_WAIT_D2 = 2'd2,
        ST_SKIP    = 2'd3
    } parser_state_t;

endpackage

// File: rtl/midi_msg_parser.sv
// MIDI byte-stream parser: tracks running status for note-on/note-off on one
// channel and emits a one-cycle event when a complete message is received.
//
// state   | meaning
// --------+---------------------------------------------------
// IDLE    | no running status, data bytes dropped
// WAIT_D1 | note status held, expecting note number
// WAIT_D2 | note number held, expecting velocity
// SKIP    | unsupported status seen, data bytes dropped
module midi_msg_parser
    import midi_defs::*;
#(
    parameter int CHANNEL = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] midi_byte,
    input  logic       midi_valid,
    output logic       evt_valid,
    output logic       evt_on,
    output logic [6:0] evt_note,
    output logic [6:0] evt_vel
);

    parser_state_t state;
    logic          status_on;
    logic [6:0]    note_hold;
    logic          blank_q;
    logic          accept;
    logic          is_our_note_status;

    // A strobe directly after an accepted one is ignored.
    assign accept = midi_valid && !blank_q;

    assign is_our_note_status = (midi_byte[3:0] == 4'(CHANNEL)) &&
                                ((midi_byte[7:4] == MIDI_NOTE_OFF[7:4]) ||
                                 (midi_byte[7:4] == MIDI_NOTE_ON[7:4]));

    // Parser FSM with running status; event outputs registered and single-cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            status_on <= 1'b0;
            note_hold <= 7'd0;
            blank_q   <= 1'b0;
            evt_valid <= 1'b0;
            evt_on    <= 1'b0;
            evt_note  <= 7'd0;
            evt_vel   <= 7'd0;
        end else begin
            evt_valid <= 1'b0;
            blank_q   <= accept;
            if (accept) begin
                if (midi_byte >= MIDI_RT_THRESHOLD) begin
                    // real-time bytes pass through without touching the parse
                    state <= state;
                end else if (midi_byte[7]) begin
                    if (is_our_note_status) begin
                        status_on <= (midi_byte[7:4] == MIDI_NOTE_ON[7:4]);
                        state     <= ST_WAIT_D1;
                    end else begin
                        state <= ST_SKIP;
                    end
                end else begin
                    case (state)
                        ST_WAIT_D1: begin
                            note_hold <= midi_byte[6:0];
                            state     <= ST_WAIT_D2;
                        end
                        ST_WAIT_D2: begin
                            evt_valid <= 1'b1;
                            evt_on    <= status_on && (midi_byte[6:0] != 7'd0);
                            evt_note  <= note_hold;
                            evt_vel   <= midi_byte[6:0];
                            state     <= ST_WAIT_D1;
                        end
                        default: state <= state;
                    endcase
                end
            end
        end
    end

endmodule

// File: rtl/midi_voice_allocator.sv
// MIDI voice allocator: assigns parsed note events to NUM_VOICES voices with
// retrigger / free-voice / LRU-steal priority and drives gate, note and amp.
// Build option: define MIDI_VOICE_STEAL_EN to steal the oldest voice when all
// voices are busy; otherwise such a note-on is dropped.
module midi_voice_allocator
    import midi_defs::*;
#(
    parameter int NUM_VOICES = DEFAULT_NUM_VOICES,
    parameter int CHANNEL    = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              midi_byte,
    input  logic                    midi_valid,
    output logic [NUM_VOICES-1:0]   voice_gate,
    output logic [8*NUM_VOICES-1:0] voice_note,
    output logic [8*NUM_VOICES-1:0] voice_amp
);

    localparam int RW = $clog2(NUM_VOICES);

`ifdef MIDI_VOICE_STEAL_EN
    localparam logic STEAL_EN = 1'b1;
`else
    localparam logic STEAL_EN = 1'b0;
`endif

    logic          evt_valid;
    logic          evt_on;
    logic [6:0]    evt_note;
    logic [6:0]    evt_vel;

    logic [NUM_VOICES-1:0] gate_q;
    logic [NUM_VOICES-1:0] restore_q;
    logic [7:0]            note_q [NUM_VOICES];
    logic [7:0]            amp_q  [NUM_VOICES];
    logic [RW-1:0]         rank_q [NUM_VOICES];

    logic          hit_found;
    logic          free_found;
    logic [RW-1:0] hit_idx;
    logic [RW-1:0] free_idx;
    logic [RW-1:0] old_idx;
    logic [RW-1:0] sel_idx;
    logic [RW-1:0] sel_rank;
    logic          sel_pulse;
    logic          alloc_ok;
    logic [7:0]    evt_note_ext;
    logic [7:0]    evt_amp;

    midi_msg_parser #(
        .CHANNEL (CHANNEL)
    ) u_parser (
        .clk        (clk),
        .rst        (rst),
        .midi_byte  (midi_byte),
        .midi_valid (midi_valid),
        .evt_valid  (evt_valid),
        .evt_on     (evt_on),
        .evt_note   (evt_note),
        .evt_vel    (evt_vel)
    );

    assign evt_note_ext = {1'b0, evt_note};
    assign evt_amp      = {evt_vel, evt_vel[6]};

    // Voice selection: a voice with a pending restore still counts as busy.
    always_comb begin
        hit_found  = 1'b0;
        free_found = 1'b0;
        hit_idx    = '0;
        free_idx   = '0;
        old_idx    = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if ((gate_q[i] || restore_q[i]) && (note_q[i] == evt_note_ext)) begin
                hit_found = 1'b1;
                hit_idx   = RW'(i);
            end
            if (!(gate_q[i] || restore_q[i])) begin
                free_found = 1'b1;
                free_idx   = RW'(i);
            end
            if (rank_q[i] == RW'(NUM_VOICES - 1)) begin
                old_idx = RW'(i);
            end
        end
        alloc_ok  = hit_found || free_found || STEAL_EN;
        sel_pulse = hit_found || !free_found;
        sel_idx   = hit_found ? hit_idx : (free_found ? free_idx : old_idx);
        sel_rank  = rank_q[sel_idx];
    end

    // Voice state, restore pulses and LRU ranks; event handling overrides restores.
    always_ff @(posedge clk) begin
        if (rst) begin
            gate_q    <= '0;
            restore_q <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_q[i] <= 8'd0;
                amp_q[i]  <= 8'd0;
                rank_q[i] <= RW'(i);
            end
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (restore_q[i]) begin
                    gate_q[i]    <= 1'b1;
                    restore_q[i] <= 1'b0;
                end
            end
            if (evt_valid) begin
                if (!evt_on) begin
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        if ((gate_q[i] || restore_q[i]) && (note_q[i] == evt_note_ext)) begin
                            gate_q[i]    <= 1'b0;
                            restore_q[i] <= 1'b0;
                        end
                    end
                end else if (alloc_ok) begin
                    note_q[sel_idx] <= evt_note_ext;
                    amp_q[sel_idx]  <= evt_amp;
                    if (sel_pulse) begin
                        gate_q[sel_idx]    <= 1'b0;
                        restore_q[sel_idx] <= 1'b1;
                    end else begin
                        gate_q[sel_idx] <= 1'b1;
                    end
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        if (RW'(i) == sel_idx) begin
                            rank_q[i] <= '0;
                        end else if (rank_q[i] < sel_rank) begin
                            rank_q[i] <= rank_q[i] + 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign voice_gate = gate_q;

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_out
        assign voice_note[8*g +: 8] = note_q[g];
        assign voice_amp[8*g +: 8]  = amp_q[g];
    end

endmodule
